ps2_arrow_judge: RTL and testbench

Receives PS/2 keyboard frames, decodes the four arrow-key make codes, and judges each press against the bottom tile row (`line_6`) during the controller's input-check window. It sits directly upstream of the game controller: it consumes `check_input_go` and `line_6`, and it returns the `correct`, `incorrect` and `check_input_done` pulses that drive scoring and the colour-line and incorrect-input stages.

---
 rtl/ps2_arrow_judge_if.sv | 33 +++
 rtl/ps2_arrow_judge.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_arrow_judge.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_arrow_judge_if.sv
// Controller-facing bundle of the arrow judge: the judge window and bottom row in,
// the judgement pulses and decoded key info out.
interface ps2_arrow_judge_if;
  logic       check_input_go;
  logic [2:0] line_6;
  logic       correct;
  logic       incorrect;
  logic       check_input_done;
  logic       key_valid;
  logic [1:0] key_lane;

  // Controller side: opens the window and presents the row, consumes the verdict.
  modport master (
    output check_input_go,
    output line_6,
    input  correct,
    input  incorrect,
    input  check_input_done,
    input  key_valid,
    input  key_lane
  );

  // Judge side.
  modport slave (
    input  check_input_go,
    input  line_6,
    output correct,
    output incorrect,
    output check_input_done,
    output key_valid,
    output key_lane
  );
endinterface

// File: rtl/ps2_arrow_judge.sv
// PS/2 receiver, extended arrow make-code decoder and press judge for the bottom tile row.
// Emits one correct/incorrect verdict per opened judge window.
module ps2_arrow_judge #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  ps2_arrow_judge_if.slave  judge
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Synchronizers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic ps2_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign ps2_fall = clk_s3_q & ~clk_s2_q;

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  logic [10:0]    shift_q;
  logic [3:0]     bit_cnt_q;
  logic [ToW-1:0] to_cnt_q;
  logic           byte_stb_q;
  logic [7:0]     byte_q;
  logic [10:0]    frame_next;
  logic           frame_ok;

  assign frame_next = {dat_s2_q, shift_q[10:1]};
  // Start low, stop high, odd parity over data plus parity bit.
  assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      byte_stb_q <= 1'b0;
      byte_q     <= '0;
    end else begin
      byte_stb_q <= 1'b0;
      if (ps2_fall) begin
        shift_q  <= frame_next;
        to_cnt_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (frame_ok) begin
            byte_stb_q <= 1'b1;
            byte_q     <= frame_next[8:1];
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        // A stalled partial frame is discarded so the next start bit realigns.
        if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + ToW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code decoder
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {DecIdle, DecExt, DecBrk, DecExtBrk} dec_state_e;

  dec_state_e dec_q;
  logic       key_valid_q;
  logic [1:0] key_lane_q;
  logic       arrow_hit;
  logic [1:0] arrow_lane;

  always_comb begin
    arrow_hit  = 1'b1;
    arrow_lane = 2'd0;
    case (byte_q)
      8'h6B:   arrow_lane = 2'd0;
      8'h72:   arrow_lane = 2'd1;
      8'h75:   arrow_lane = 2'd2;
      8'h74:   arrow_lane = 2'd3;
      default: arrow_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q       <= DecIdle;
      key_valid_q <= 1'b0;
      key_lane_q  <= 2'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (byte_stb_q) begin
        unique case (dec_q)
          DecIdle: begin
            if (byte_q == 8'hE0)      dec_q <= DecExt;
            else if (byte_q == 8'hF0) dec_q <= DecBrk;
            else                      dec_q <= DecIdle;
          end
          DecExt: begin
            if (byte_q == 8'hF0) begin
              dec_q <= DecExtBrk;
            end else begin
              dec_q <= DecIdle;
              if (arrow_hit) begin
                key_valid_q <= 1'b1;
                key_lane_q  <= arrow_lane;
              end
            end
          end
          // Break codes swallow the following byte; releases are not events.
          DecBrk, DecExtBrk: dec_q <= DecIdle;
          default:           dec_q <= DecIdle;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Judge
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {JdgIdle, JdgArmed, JdgDone} jdg_state_e;

  jdg_state_e jdg_q;
  logic       go_q;
  logic       arm_new_q;
  logic       correct_q;
  logic       incorrect_q;
  logic       done_q;
  logic       lane_match;

  assign lane_match = judge.line_6[2] & (judge.line_6[1:0] == key_lane_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jdg_q       <= JdgIdle;
      go_q        <= 1'b0;
      arm_new_q   <= 1'b0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      go_q        <= judge.check_input_go;
      arm_new_q   <= 1'b0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (jdg_q)
        JdgIdle: begin
          if (judge.check_input_go && !go_q) begin
            jdg_q     <= JdgArmed;
            arm_new_q <= 1'b1;
          end
        end
        JdgArmed: begin
          // Abort wins over a coincident event; an event in the opening cycle is too early.
          if (!judge.check_input_go) begin
            jdg_q <= JdgIdle;
          end else if (key_valid_q && !arm_new_q) begin
            correct_q   <= lane_match;
            incorrect_q <= ~lane_match;
            done_q      <= 1'b1;
            jdg_q       <= JdgDone;
          end
        end
        JdgDone: begin
          if (!judge.check_input_go) jdg_q <= JdgIdle;
        end
        default: jdg_q <= JdgIdle;
      endcase
    end
  end

  assign judge.correct          = correct_q;
  assign judge.incorrect        = incorrect_q;
  assign judge.check_input_done = done_q;
  assign judge.key_valid        = key_valid_q;
  assign judge.key_lane         = key_lane_q;

endmodule

// File: tb/tb_ps2_arrow_judge.sv
// Directed bench for ps2_arrow_judge: bit-bangs PS/2 frames and checks judge pulses.
module tb_ps2_arrow_judge;

  localparam int unsigned Timeout = 200;
  localparam int          Half    = 20;

  logic clock;
  logic reset;
  logic ps2_clk;
  logic ps2_dat;

  ps2_arrow_judge_if bus ();

  ps2_arrow_judge #(
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .judge   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse tallies sampled on the falling edge, away from the active edge.
  int n_corr = 0;
  int n_inc  = 0;
  int n_done = 0;
  int n_kv   = 0;
  int n_coin = 0;

  always @(negedge clock) begin
    if (bus.correct)          n_corr++;
    if (bus.incorrect)        n_inc++;
    if (bus.check_input_done) n_done++;
    if (bus.key_valid)        n_kv++;
    if ((bus.check_input_done !== (bus.correct | bus.incorrect)) ||
        (bus.correct && bus.incorrect)) n_coin++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends nbits of an 11-bit frame; a full frame is followed by an idle gap.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      wait_cycles(Half);
      ps2_clk = 1'b0;
      wait_cycles(Half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    if (nbits == 11) wait_cycles(60);
  endtask

  task automatic open_window(input logic [2:0] line);
    bus.line_6         = line;
    bus.check_input_go = 1'b1;
    wait_cycles(5);
  endtask

  task automatic close_window();
    bus.check_input_go = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    ps2_clk            = 1'b1;
    ps2_dat            = 1'b1;
    bus.check_input_go = 1'b0;
    bus.line_6         = 3'b000;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(5);
    n_cmp++; if (bus.correct !== 1'b0) begin n_err++;
      $display("FAIL reset_correct: got %b want 0", bus.correct); end
    n_cmp++; if (bus.incorrect !== 1'b0) begin n_err++;
      $display("FAIL reset_incorrect: got %b want 0", bus.incorrect); end
    n_cmp++; if (bus.check_input_done !== 1'b0) begin n_err++;
      $display("FAIL reset_done: got %b want 0", bus.check_input_done); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_key_valid: got %b want 0", bus.key_valid); end
    n_cmp++; if (bus.key_lane !== 2'd0) begin n_err++;
      $display("FAIL reset_key_lane: got %0d want 0", bus.key_lane); end
  endtask

  task automatic test_correct();
    int c0, i0, d0, k0;
    c0 = n_corr; i0 = n_inc; d0 = n_done; k0 = n_kv;
    open_window(3'b101);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h72, 1'b0, 11);
    n_cmp++; if (n_corr - c0 !== 1) begin n_err++;
      $display("FAIL down_correct: got %0d cycles want 1", n_corr - c0); end
    n_cmp++; if (n_inc - i0 !== 0) begin n_err++;
      $display("FAIL down_incorrect: got %0d cycles want 0", n_inc - i0); end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++;
      $display("FAIL down_done: got %0d cycles want 1", n_done - d0); end
    n_cmp++; if (n_kv - k0 !== 1) begin n_err++;
      $display("FAIL down_key_valid: got %0d cycles want 1", n_kv - k0); end
    n_cmp++; if (bus.key_lane !== 2'd1) begin n_err++;
      $display("FAIL down_key_lane: got %0d want 1", bus.key_lane); end
    close_window();
  endtask

  task automatic test_wrong_lane();
    int c0, i0, d0, k0;
    c0 = n_corr; i0 = n_inc; d0 = n_done;
    open_window(3'b111);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 11);
    n_cmp++; if (n_inc - i0 !== 1) begin n_err++;
      $display("FAIL wrong_incorrect: got %0d cycles want 1", n_inc - i0); end
    n_cmp++; if (n_corr - c0 !== 0) begin n_err++;
      $display("FAIL wrong_correct: got %0d cycles want 0", n_corr - c0); end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++;
      $display("FAIL wrong_done: got %0d cycles want 1", n_done - d0); end
    n_cmp++; if (bus.key_lane !== 2'd0) begin n_err++;
      $display("FAIL wrong_key_lane: got %0d want 0", bus.key_lane); end
    // Second press in the same window: key seen, verdict already given.
    d0 = n_done; k0 = n_kv;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    n_cmp++; if (n_done - d0 !== 0) begin n_err++;
      $display("FAIL done_ignores_done: got %0d cycles want 0", n_done - d0); end
    n_cmp++; if (n_kv - k0 !== 1) begin n_err++;
      $display("FAIL done_key_valid: got %0d cycles want 1", n_kv - k0); end
    n_cmp++; if (bus.key_lane !== 2'd3) begin n_err++;
      $display("FAIL done_key_lane: got %0d want 3", bus.key_lane); end
    close_window();
  endtask

  task automatic test_no_tile();
    int i0, d0, k0;
    i0 = n_inc;
    open_window(3'b000);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    n_cmp++; if (n_inc - i0 !== 1) begin n_err++;
      $display("FAIL no_tile_incorrect: got %0d cycles want 1", n_inc - i0); end
    n_cmp++; if (bus.key_lane !== 2'd2) begin n_err++;
      $display("FAIL no_tile_key_lane: got %0d want 2", bus.key_lane); end
    close_window();
    // Extended break inside a fresh window: nothing at all.
    d0 = n_done; k0 = n_kv;
    open_window(3'b110);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    n_cmp++; if (n_kv - k0 !== 0) begin n_err++;
      $display("FAIL break_key_valid: got %0d cycles want 0", n_kv - k0); end
    n_cmp++; if (n_done - d0 !== 0) begin n_err++;
      $display("FAIL break_done: got %0d cycles want 0", n_done - d0); end
    close_window();
  endtask

  task automatic test_outside_window();
    int c0, d0, k0;
    d0 = n_done; k0 = n_kv;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    n_cmp++; if (n_kv - k0 !== 1) begin n_err++;
      $display("FAIL outside_key_valid: got %0d cycles want 1", n_kv - k0); end
    open_window(3'b111);
    wait_cycles(50);
    n_cmp++; if (n_done - d0 !== 0) begin n_err++;
      $display("FAIL stale_key_done: got %0d cycles want 0", n_done - d0); end
    c0 = n_corr;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    n_cmp++; if (n_corr - c0 !== 1) begin n_err++;
      $display("FAIL right_correct: got %0d cycles want 1", n_corr - c0); end
    close_window();
  endtask

  task automatic test_bad_frames();
    int c0, d0, k0;
    d0 = n_done; k0 = n_kv;
    open_window(3'b100);
    send_frame(8'h6B, 1'b0, 11);  // arrow code without E0 prefix
    send_frame(8'hE0, 1'b1, 11);  // parity error
    send_frame(8'hE0, 1'b0, 6);   // truncated frame
    wait_cycles(Timeout + 50);
    n_cmp++; if (n_kv - k0 !== 0) begin n_err++;
      $display("FAIL bad_frames_key_valid: got %0d cycles want 0", n_kv - k0); end
    n_cmp++; if (n_done - d0 !== 0) begin n_err++;
      $display("FAIL bad_frames_done: got %0d cycles want 0", n_done - d0); end
    c0 = n_corr;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 11);
    n_cmp++; if (n_corr - c0 !== 1) begin n_err++;
      $display("FAIL after_timeout_correct: got %0d cycles want 1", n_corr - c0); end
    close_window();
  endtask

  task automatic test_reset_mid();
    int c0;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    open_window(3'b101);
    send_frame(8'h72, 1'b0, 5);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.key_lane !== 2'd0) begin n_err++;
      $display("FAIL async_reset_key_lane: got %0d want 0", bus.key_lane); end
    n_cmp++; if ({bus.correct, bus.incorrect, bus.check_input_done, bus.key_valid} !== 4'b0)
      begin n_err++;
      $display("FAIL async_reset_pulses: got %b want 0000",
               {bus.correct, bus.incorrect, bus.check_input_done, bus.key_valid}); end
    bus.check_input_go = 1'b0;
    ps2_clk            = 1'b1;
    ps2_dat            = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(5);
    c0 = n_corr;
    open_window(3'b101);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h72, 1'b0, 11);
    n_cmp++; if (n_corr - c0 !== 1) begin n_err++;
      $display("FAIL post_reset_correct: got %0d cycles want 1", n_corr - c0); end
    n_cmp++; if (bus.key_lane !== 2'd1) begin n_err++;
      $display("FAIL post_reset_key_lane: got %0d want 1", bus.key_lane); end
    close_window();
    n_cmp++; if (n_coin !== 0) begin n_err++;
      $display("FAIL done_coincidence: got %0d bad cycles want 0", n_coin); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong_lane();
    test_no_tile();
    test_outside_window();
    test_bad_frames();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
